// File: rtl/mini_mips_pkg.sv
// Shared encodings for the multicycle MIPS subset controller: FSM states,
// opcode/funct constants and the ALU operation codes.
package mini_mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14,
        S_HALT    = 4'd15
    } state_e;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ADD2  = 2'b11
    } aluop_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mini_mips_aludec.sv
// ALU control decode: maps the controller's aluop plus the R-type funct field
// onto the 3-bit ALU operation code.
module mini_mips_aludec
    import mini_mips_pkg::*;
(
    input  aluop_e      aluop_i,
    input  logic [5:0]  funct_i,
    output logic [2:0]  alucont_o
);

    always_comb begin
        alucont_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alucont_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alucont_o = ALU_ADD;
                    FUNCT_SUB: alucont_o = ALU_SUB;
                    FUNCT_AND: alucont_o = ALU_AND;
                    FUNCT_OR:  alucont_o = ALU_OR;
                    FUNCT_SLT: alucont_o = ALU_SLT;
                    default:   alucont_o = ALU_ADD;
                endcase
            end
            default: alucont_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mini_mips_controller.sv
// Moore FSM controller for a byte-fetch multicycle MIPS subset
// (LB, SB, R-type, BEQ, J, ADDI) with optional trap on illegal opcodes.
module mini_mips_controller
    import mini_mips_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic [3:0] irwrite,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [2:0] alucont,
    output logic       pcen,
    output logic       illegal_op,
    output logic       halted
);

    state_e state_q, state_d;
    aluop_e aluop;
    logic   pcwrite;
    logic   pcwritecond;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        memread     = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        alusrca     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        irwrite     = 4'b0000;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        aluop       = ALUOP_ADD;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        illegal_op  = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
            end
            default: ;
        endcase

        case (state_q)
            S_FETCH1: begin
                irwrite = 4'b0001;
                state_d = S_FETCH2;
            end
            S_FETCH2: begin
                irwrite = 4'b0010;
                state_d = S_FETCH3;
            end
            S_FETCH3: begin
                irwrite = 4'b0100;
                state_d = S_FETCH4;
            end
            S_FETCH4: begin
                irwrite = 4'b1000;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = ILLEGAL_TRAP ? S_HALT : S_FETCH1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LB) ? S_LBRD : S_SBWR;
            end
            S_LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = S_LBWR;
            end
            S_LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH1;
            end
            S_SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                state_d  = S_FETCH1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = S_FETCH1;
            end
            S_BEQEX: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                state_d     = S_FETCH1;
            end
            S_JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
                state_d  = S_FETCH1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWR;
            end
            S_ADDIWR: begin
                regwrite = 1'b1;
                state_d  = S_FETCH1;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH1;
        endcase
    end

    // Branch resolution is the only output that looks at a live datapath flag.
    assign pcen = pcwrite | (pcwritecond & zero);

    mini_mips_aludec u_aludec (
        .aluop_i   (aluop),
        .funct_i   (funct),
        .alucont_o (alucont)
    );

endmodule

// File: tb/tb_mini_mips_controller.sv
// Scoreboard bench: stimulus pushes per-cycle expected control vectors, a
// negedge monitor pops and compares them against the non-trapping instance.
module tb_mini_mips_controller;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       alusrca;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic [3:0] irwrite;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [2:0] alucont;
        logic       pcen;
        logic       illegal_op;
        logic       halted;
    } ctl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, reset1;
    logic [5:0] op0, funct0, op1;
    logic       zero0;

    logic       memread0, memwrite0, iord0, alusrca0, memtoreg0, regdst0, regwrite0;
    logic [3:0] irwrite0;
    logic [1:0] alusrcb0, pcsource0;
    logic [2:0] alucont0;
    logic       pcen0, illegal_op0, halted0;

    logic       memread1, memwrite1, iord1, alusrca1, memtoreg1, regdst1, regwrite1;
    logic [3:0] irwrite1;
    logic [1:0] alusrcb1, pcsource1;
    logic [2:0] alucont1;
    logic       pcen1, illegal_op1, halted1;

    ctl_t act0, act1;
    assign act0 = {memread0, memwrite0, iord0, alusrca0, memtoreg0, regdst0, regwrite0,
                   irwrite0, alusrcb0, pcsource0, alucont0, pcen0, illegal_op0, halted0};
    assign act1 = {memread1, memwrite1, iord1, alusrca1, memtoreg1, regdst1, regwrite1,
                   irwrite1, alusrcb1, pcsource1, alucont1, pcen1, illegal_op1, halted1};

    mini_mips_controller #(.ILLEGAL_TRAP(1'b0)) dut_skip (
        .clk(clk), .reset(reset0), .op(op0), .funct(funct0), .zero(zero0),
        .memread(memread0), .memwrite(memwrite0), .iord(iord0), .alusrca(alusrca0),
        .memtoreg(memtoreg0), .regdst(regdst0), .regwrite(regwrite0), .irwrite(irwrite0),
        .alusrcb(alusrcb0), .pcsource(pcsource0), .alucont(alucont0), .pcen(pcen0),
        .illegal_op(illegal_op0), .halted(halted0)
    );

    mini_mips_controller #(.ILLEGAL_TRAP(1'b1)) dut_trap (
        .clk(clk), .reset(reset1), .op(op1), .funct(6'b000000), .zero(1'b1),
        .memread(memread1), .memwrite(memwrite1), .iord(iord1), .alusrca(alusrca1),
        .memtoreg(memtoreg1), .regdst(regdst1), .regwrite(regwrite1), .irwrite(irwrite1),
        .alusrcb(alusrcb1), .pcsource(pcsource1), .alucont(alucont1), .pcen(pcen1),
        .illegal_op(illegal_op1), .halted(halted1)
    );

    int   checks = 0;
    int   errors = 0;
    ctl_t expq[$];
    string nameq[$];

    // Reference model: control vectors built directly from the per-step rules.
    function automatic ctl_t v_idle();
        ctl_t v = '0;
        v.alucont = 3'b010;
        return v;
    endfunction

    function automatic ctl_t v_fetch(int n);
        ctl_t v = v_idle();
        v.memread = 1'b1;
        v.irwrite = 4'b0001 << (n - 1);
        v.alusrcb = 2'b01;
        v.pcen    = 1'b1;
        return v;
    endfunction

    function automatic logic [2:0] alu_ref(logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit legal(logic [5:0] o);
        return o inside {6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    task automatic expect_cycle(input ctl_t v, input string nm);
        expq.push_back(v);
        nameq.push_back(nm);
    endtask

    // Drives one instruction and queues its expected cycles; returns latency.
    task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                              input string nm, output int n);
        ctl_t v;
        op0 = o; funct0 = f; zero0 = z;
        for (int i = 1; i <= 4; i++) expect_cycle(v_fetch(i), $sformatf("%s_fetch%0d", nm, i));
        v = v_idle(); v.alusrcb = 2'b11; v.illegal_op = !legal(o);
        expect_cycle(v, {nm, "_decode"});
        n = 5;
        if (o == 6'b100000 || o == 6'b101000) begin
            v = v_idle(); v.alusrca = 1'b1; v.alusrcb = 2'b10;
            expect_cycle(v, {nm, "_memadr"});
            if (o == 6'b100000) begin
                v = v_idle(); v.memread = 1'b1; v.iord = 1'b1;
                expect_cycle(v, {nm, "_lbrd"});
                v = v_idle(); v.regwrite = 1'b1; v.memtoreg = 1'b1;
                expect_cycle(v, {nm, "_lbwr"});
                n = 8;
            end else begin
                v = v_idle(); v.memwrite = 1'b1; v.iord = 1'b1;
                expect_cycle(v, {nm, "_sbwr"});
                n = 7;
            end
        end else if (o == 6'b000000) begin
            v = v_idle(); v.alusrca = 1'b1; v.alucont = alu_ref(f);
            expect_cycle(v, {nm, "_rex"});
            v = v_idle(); v.regwrite = 1'b1; v.regdst = 1'b1;
            expect_cycle(v, {nm, "_rwr"});
            n = 7;
        end else if (o == 6'b001000) begin
            v = v_idle(); v.alusrca = 1'b1; v.alusrcb = 2'b10;
            expect_cycle(v, {nm, "_addiex"});
            v = v_idle(); v.regwrite = 1'b1;
            expect_cycle(v, {nm, "_addiwr"});
            n = 7;
        end else if (o == 6'b000100) begin
            v = v_idle(); v.alusrca = 1'b1; v.alucont = 3'b110; v.pcsource = 2'b01; v.pcen = z;
            expect_cycle(v, {nm, "_beqex"});
            n = 6;
        end else if (o == 6'b000010) begin
            v = v_idle(); v.pcsource = 2'b10; v.pcen = 1'b1;
            expect_cycle(v, {nm, "_jex"});
            n = 6;
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input string nm);
        int n;
        push_instr(o, f, z, nm, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input ctl_t a, input ctl_t e, input string nm);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        ctl_t  e;
        string nm;
        if (expq.size() > 0) begin
            e  = expq.pop_front();
            nm = nameq.pop_front();
            checks++;
            if (act0 !== e) begin
                errors++;
                $display("FAIL %s got %h want %h", nm, act0, e);
            end
        end
    end

    initial begin
        ctl_t v;
        int   n;
        logic [5:0] o, f;
        reset0 = 1'b0; reset1 = 1'b0;
        op0 = 6'b0; funct0 = 6'b0; zero0 = 1'b0; op1 = 6'b111111;

        repeat (3) @(posedge clk);
        #1;
        check_vec(act0, v_fetch(1), "reset_hold_skip");
        check_vec(act1, v_fetch(1), "reset_hold_trap");
        @(posedge clk); #1;
        reset0 = 1'b1;

        run_instr(6'b100000, 6'b000000, 1'b0, "lb");
        run_instr(6'b101000, 6'b000000, 1'b1, "sb");
        run_instr(6'b000000, 6'b100010, 1'b0, "rsub");
        run_instr(6'b000100, 6'b000000, 1'b1, "beq_taken");
        run_instr(6'b000100, 6'b000000, 1'b0, "beq_not");
        run_instr(6'b000010, 6'b000000, 1'b0, "j");
        run_instr(6'b001000, 6'b000000, 1'b0, "addi");
        run_instr(6'b111111, 6'b000000, 1'b0, "illegal");
        run_instr(6'b000000, 6'b101010, 1'b1, "rslt");

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0: o = 6'b100000;
                1: o = 6'b101000;
                2: o = 6'b000000;
                3: o = 6'b000100;
                4: o = 6'b000010;
                5: o = 6'b001000;
                default: begin
                    o = 6'($urandom_range(0, 63));
                    while (legal(o)) o = 6'($urandom_range(0, 63));
                end
            endcase
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 4))
                    0: f = 6'b100000;
                    1: f = 6'b100010;
                    2: f = 6'b100100;
                    3: f = 6'b100101;
                    default: f = 6'b101010;
                endcase
            end else begin
                f = 6'($urandom_range(0, 63));
            end
            run_instr(o, f, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        // LB interrupted by an asynchronous reset while in LBRD.
        push_instr(6'b100000, 6'b000000, 1'b0, "lb_abort", n);
        void'(expq.pop_back());
        void'(nameq.pop_back());
        repeat (6) @(posedge clk);
        @(negedge clk); #2;
        reset0 = 1'b0;
        #1;
        check_vec(act0, v_fetch(1), "abort_async_fetch1");
        @(posedge clk); #1;
        check_vec(act0, v_fetch(1), "abort_no_regwrite");
        reset0 = 1'b1;
        run_instr(6'b001000, 6'b000000, 1'b0, "after_abort");

        // Trapping instance: illegal opcode halts until reset.
        @(posedge clk); #1;
        reset1 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                v = v_fetch(c);
            end else if (c == 5) begin
                v = v_idle(); v.alusrcb = 2'b11; v.illegal_op = 1'b1;
            end else begin
                v = v_idle(); v.halted = 1'b1;
            end
            check_vec(act1, v, $sformatf("trap_c%0d", c));
        end
        #2;
        reset1 = 1'b0;
        #1;
        check_vec(act1, v_fetch(1), "trap_reset_fetch1");
        @(posedge clk); #1;
        reset1 = 1'b1;
        @(negedge clk);
        check_vec(act1, v_fetch(1), "trap_resume_fetch1");
        @(negedge clk);
        check_vec(act1, v_fetch(2), "trap_resume_fetch2");

        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
